regfile_2r1w: RTL

Architectural register file for the single-cycle MIPS datapath, directly downstream of the write-back selection muxes. Its write address comes from the 3:1×5 destination mux (rd / rt / 31), and its write data from the 2:1×32 mux (ALU result / PC+4, used for JAL link). It provides 32 general-purpose registers with two combinational read ports and one clocked write port. Register 0 is hardwired to zero.

---
 rtl/regfile_2r1w_pkg.sv | 9 +
 rtl/regfile_2r1w_if.sv | 27 ++
 rtl/regfile_2r1w_register32.sv | 21 ++
 rtl/regfile_2r1w.sv | 58 +++++
 4 files changed

// File: rtl/regfile_2r1w_pkg.sv
// Shared constants for the 2-read/1-write architectural register file.
// Optional write-to-read forwarding is enabled with REGFILE_BYPASS_EN.
package regfile_2r1w_pkg;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int ZERO_REG   = 0;
  localparam int LINK_REG   = 31;
endpackage

// File: rtl/regfile_2r1w_if.sv
// Write and read port bundle between the datapath and the register file.
interface regfile_2r1w_if
  import regfile_2r1w_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) ();
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [WIDTH-1:0]  WriteData;
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [WIDTH-1:0]  ReadData1;
  logic [WIDTH-1:0]  ReadData2;

  modport master (
    output RegWrite, WriteRegister, WriteData,
    output ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData,
    input  ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2
  );
endinterface

// File: rtl/regfile_2r1w_register32.sv
// One architectural register: WIDTH-bit flop with enable and
// synchronous active-low clear.
module register32
  import regfile_2r1w_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end
endmodule

// File: rtl/regfile_2r1w.sv
// Register file: r0 constant zero, r1..r(N-1) flops, two async reads.
// Define REGFILE_BYPASS_EN to forward the pending write onto read ports.
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic clk,
  input  logic reset_n,
  regfile_2r1w_if.slave rf
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:1] wr_en;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] arr1;
  logic [WIDTH-1:0] arr2;

  always_comb begin
    wr_en = '0;
    for (int i = 1; i < DEPTH; i++) begin
      wr_en[i] = rf.RegWrite &&
                 (rf.WriteRegister == ADDR_W'(i));
    end
  end

  assign regs[ZERO_REG] = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_reg
    register32 #(.WIDTH(WIDTH)) u_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (wr_en[i]),
      .d       (rf.WriteData),
      .q       (regs[i])
    );
  end

  assign arr1 = regs[rf.ReadRegister1];
  assign arr2 = regs[rf.ReadRegister2];

`ifdef REGFILE_BYPASS_EN
  // Reset and r0 both suppress forwarding.
  logic byp_ok;
  assign byp_ok = reset_n && rf.RegWrite &&
                  (rf.WriteRegister != '0);
  assign rf.ReadData1 =
    (byp_ok && rf.ReadRegister1 == rf.WriteRegister)
      ? rf.WriteData : arr1;
  assign rf.ReadData2 =
    (byp_ok && rf.ReadRegister2 == rf.WriteRegister)
      ? rf.WriteData : arr2;
`else
  assign rf.ReadData1 = arr1;
  assign rf.ReadData2 = arr2;
`endif
endmodule
